// File: rtl/mem_stage_lsu_pkg.sv
// mem_pkg: shared encodings for the MEM-stage load/store unit.
//   load_op_e   : load operation encoding carried from EX.
//   lsu_state_e : response-tracking FSM states.
//   STALL_MEM / STALL_WB : bit positions in the pipeline stall vector.
package mem_pkg;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_LB   = 3'd1,
    OP_LBU  = 3'd2,
    OP_LH   = 3'd3,
    OP_LHU  = 3'd4,
    OP_LW   = 3'd5,
    OP_LWU  = 3'd6,
    OP_LD   = 3'd7
  } load_op_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,  // no response pending or buffered
    ST_WAIT  = 2'd1,  // load in stage, response outstanding
    ST_FULL  = 2'd2,  // response captured, entry held by a stall
    ST_DRAIN = 2'd3   // flushed load's response still to arrive
  } lsu_state_e;

  localparam int STALL_MEM = 3;
  localparam int STALL_WB  = 4;

endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// load_align: combinational lane select and extension for loads.
//   raw  : naturally aligned memory word (XLEN)
//   off  : byte offset of the access inside the word
//   op   : load operation
//   data : shifted and sign/zero-extended result (XLEN)
// Misaligned offsets are not trapped; the shifted lane is used as-is.
module load_align
  import mem_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OFF_W = $clog2(XLEN/8)
) (
  input  logic [XLEN-1:0]  raw,
  input  logic [OFF_W-1:0] off,
  input  load_op_e         op,
  output logic [XLEN-1:0]  data
);

  logic [XLEN-1:0] lane;

  assign lane = raw >> {off, 3'b000};

  // With XLEN=32, LWU and LD collapse onto LW: a 32-bit zero-extend and
  // the full lane are both the 32-bit word itself.
  always_comb begin
    data = lane;
    case (op)
      OP_LB:   data = XLEN'($signed(lane[7:0]));
      OP_LBU:  data = XLEN'(lane[7:0]);
      OP_LH:   data = XLEN'($signed(lane[15:0]));
      OP_LHU:  data = XLEN'(lane[15:0]);
      OP_LW:   data = XLEN'($signed(lane[31:0]));
      OP_LWU:  data = XLEN'(lane[31:0]);
      OP_LD:   data = lane;
      default: data = lane;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM pipeline stage between EX and WB with sub-word loads,
// variable-latency memory responses, a one-entry response buffer and
// discard of responses that belong to flushed loads.
//   clk, rst (async, active low), flush, stall[STALL_W]
//   ex_*        : entry presented by EX
//   mem_rvalid/mem_rdata : data-memory read response
//   stallreq    : hold request while a load lacks data
//   wb_*        : combinational outputs to WB / ID forwarding
module mem_stage_lsu
  import mem_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int PC_W    = 32,
  parameter int REG_AW  = 5,
  parameter int STALL_W = 6,
  parameter int OFF_W   = $clog2(XLEN/8)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [STALL_W-1:0] stall,
  input  logic               ex_valid,
  input  logic [PC_W-1:0]    ex_pc,
  input  logic [2:0]         ex_load_op,
  input  logic [OFF_W-1:0]   ex_addr_lo,
  input  logic               ex_rf_we,
  input  logic [REG_AW-1:0]  ex_rf_waddr,
  input  logic [XLEN-1:0]    ex_result,
  input  logic               mem_rvalid,
  input  logic [XLEN-1:0]    mem_rdata,
  output logic               stallreq,
  output logic               wb_valid,
  output logic [PC_W-1:0]    wb_pc,
  output logic               wb_rf_we,
  output logic [REG_AW-1:0]  wb_rf_waddr,
  output logic [XLEN-1:0]    wb_rf_wdata
);

  typedef struct packed {
    logic              valid;
    logic [PC_W-1:0]   pc;
    load_op_e          op;
    logic [OFF_W-1:0]  addr_lo;
    logic              rf_we;
    logic [REG_AW-1:0] waddr;
    logic [XLEN-1:0]   result;
  } entry_t;

  entry_t          ent, ent_in;
  lsu_state_e      state;
  logic [XLEN-1:0] resp_buf;
  logic            is_load, leave, buf_full, data_ok;
  logic [XLEN-1:0] raw, aligned;
  logic            stall_unused;

  assign stall_unused = ^stall;

  assign ent_in = '{valid:   ex_valid,
                    pc:      ex_pc,
                    op:      load_op_e'(ex_load_op),
                    addr_lo: ex_addr_lo,
                    rf_we:   ex_rf_we,
                    waddr:   ex_rf_waddr,
                    result:  ex_result};

  // Stage register: flush beats stall; MEM stalled with WB running
  // forwards a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                       ent <= '0;
    else if (flush)                                 ent <= '0;
    else if (stall[STALL_MEM] && !stall[STALL_WB])  ent <= '0;
    else if (!stall[STALL_MEM])                     ent <= ent_in;
  end

  assign is_load  = ent.valid && (ent.op != OP_NONE);
  assign leave    = !stall[STALL_MEM];
  assign buf_full = (state == ST_FULL);
  assign data_ok  = buf_full | mem_rvalid;
  // In DRAIN the arriving response belongs to the flushed load.
  assign stallreq = is_load && (!data_ok || (state == ST_DRAIN));

  // Response tracking. A response is buffered only when the entry stays
  // in the stage; if it leaves the same cycle, WB has already taken it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_EMPTY;
      resp_buf <= '0;
    end else if (flush) begin
      resp_buf <= '0;
      // A response arriving together with the flush is the killed load's.
      if ((state == ST_WAIT || state == ST_DRAIN) && !mem_rvalid)
        state <= ST_DRAIN;
      else
        state <= ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY, ST_WAIT: begin
          if (is_load) begin
            if (mem_rvalid) begin
              if (leave) begin
                state <= ST_EMPTY;
              end else begin
                state    <= ST_FULL;
                resp_buf <= mem_rdata;
              end
            end else begin
              state <= ST_WAIT;
            end
          end else if (state == ST_WAIT && !mem_rvalid) begin
            // waiting load replaced by a bubble: its response is stale
            state <= ST_DRAIN;
          end else begin
            state <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (leave || !is_load) begin
            state    <= ST_EMPTY;
            resp_buf <= '0;
          end
        end
        ST_DRAIN: begin
          if (mem_rvalid) state <= ST_EMPTY;
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

  assign raw = buf_full ? resp_buf : mem_rdata;

  load_align #(.XLEN(XLEN)) u_align (
    .raw  (raw),
    .off  (ent.addr_lo),
    .op   (ent.op),
    .data (aligned)
  );

  assign wb_valid    = ent.valid && !stallreq;
  assign wb_rf_we    = wb_valid && ent.rf_we;
  assign wb_pc       = ent.pc;
  assign wb_rf_waddr = ent.waddr;
  assign wb_rf_wdata = is_load ? aligned : ent.result;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: a 32-bit and a 64-bit instance share one
// stimulus stream; a transaction-level model predicts outputs each cycle.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic [5:0]  stall = '0;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_pc = '0;
  logic [2:0]  ex_load_op = '0;
  logic [2:0]  ex_addr_lo = '0;
  logic        ex_rf_we = 1'b0;
  logic [4:0]  ex_rf_waddr = '0;
  logic [63:0] ex_result = '0;
  logic        mem_rvalid = 1'b0;
  logic [63:0] mem_rdata = '0;

  logic        a_stallreq, a_wbv, a_we;
  logic [31:0] a_pc, a_wdata;
  logic [4:0]  a_waddr;
  logic        b_stallreq, b_wbv, b_we;
  logic [31:0] b_pc;
  logic [63:0] b_wdata;
  logic [4:0]  b_waddr;

  always #5 clk = ~clk;

  mem_stage_lsu #(.XLEN(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_load_op(ex_load_op),
    .ex_addr_lo(ex_addr_lo[1:0]), .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr),
    .ex_result(ex_result[31:0]), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata[31:0]),
    .stallreq(a_stallreq), .wb_valid(a_wbv), .wb_pc(a_pc), .wb_rf_we(a_we),
    .wb_rf_waddr(a_waddr), .wb_rf_wdata(a_wdata));

  mem_stage_lsu #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_load_op(ex_load_op),
    .ex_addr_lo(ex_addr_lo), .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr),
    .ex_result(ex_result), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stallreq(b_stallreq), .wb_valid(b_wbv), .wb_pc(b_pc), .wb_rf_we(b_we),
    .wb_rf_waddr(b_waddr), .wb_rf_wdata(b_wdata));

  typedef struct {
    logic v; logic [2:0] op; logic [2:0] off; logic we; logic [4:0] wa;
    logic [63:0] res; logic [31:0] pc; logic rv; logic [63:0] rd;
    logic fl; logic s3; logic s4;
  } stim_t;

  int n_cmp = 0, n_bad = 0;

  // model: the instruction in the stage plus the fate of its response
  logic        m_valid, m_we, m_have, m_discard, m_waiting;
  logic [2:0]  m_op, m_off;
  logic [4:0]  m_waddr;
  logic [31:0] m_pc;
  logic [63:0] m_res, m_data;
  int          q[$];          // per outstanding request: cycles until reply
  bit          rand_mode = 0;

  logic        l_stall, l_wbv, l_we;
  logic [31:0] l_a_wdata;
  logic [63:0] l_b_wdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [63:0] align(input logic [63:0] rw, input logic [2:0] off,
                                        input logic [2:0] op, input int xl);
    logic [63:0] w, lane, r, mask;
    mask = (xl == 32) ? 64'hFFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    w    = rw & mask;
    lane = (xl == 32) ? (w >> (int'(off[1:0]) * 8)) : (w >> (int'(off) * 8));
    case (op)
      3'd1: r = {{56{lane[7]}}, lane[7:0]};
      3'd2: r = {56'h0, lane[7:0]};
      3'd3: r = {{48{lane[15]}}, lane[15:0]};
      3'd4: r = {48'h0, lane[15:0]};
      3'd5: r = {{32{lane[31]}}, lane[31:0]};
      3'd6: r = (xl == 64) ? {32'h0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
      3'd7: r = (xl == 64) ? lane : {{32{lane[31]}}, lane[31:0]};
      default: r = lane;
    endcase
    return r & mask;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_we = 0; m_have = 0; m_discard = 0; m_waiting = 0;
    m_op = 0; m_off = 0; m_waddr = 0; m_pc = 0; m_res = 0; m_data = 0;
    q.delete();
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.v = 0; s.op = 0; s.off = 0; s.we = 0; s.wa = 0; s.res = 0; s.pc = 0;
    s.rv = 0; s.rd = 0; s.fl = 0; s.s3 = 0; s.s4 = 0;
    return s;
  endfunction

  // One clock: drive at negedge, compare against the model, advance the model.
  task automatic step(input stim_t s);
    logic is_ld, avail, e_stall, e_wbv, e_we, s3e, s4e, od;
    logic [63:0] rw, e_w64, e_w32;
    @(negedge clk);
    ex_valid = s.v; ex_load_op = s.op; ex_addr_lo = s.off; ex_rf_we = s.we;
    ex_rf_waddr = s.wa; ex_result = s.res; ex_pc = s.pc;
    mem_rvalid = s.rv; mem_rdata = s.rd; flush = s.fl;
    is_ld   = m_valid && (m_op != 3'd0);
    avail   = m_have || (s.rv && !m_discard);
    e_stall = is_ld && !avail;
    e_wbv   = m_valid && !e_stall;
    e_we    = e_wbv && m_we;
    rw      = m_have ? m_data : s.rd;
    e_w64   = is_ld ? align(rw, m_off, m_op, 64) : m_res;
    e_w32   = is_ld ? align(rw, m_off, m_op, 32) : {32'h0, m_res[31:0]};
    // the hazard unit stalls everything up to WB while stallreq is high
    s3e = s.s3 | e_stall;
    s4e = s.s4 | e_stall;
    stall = {1'b0, s4e, s3e, s3e, s3e, s3e};
    #1;
    chk("stallreq32", 64'(a_stallreq), 64'(e_stall));
    chk("stallreq64", 64'(b_stallreq), 64'(e_stall));
    chk("wb_valid32", 64'(a_wbv), 64'(e_wbv));
    chk("wb_valid64", 64'(b_wbv), 64'(e_wbv));
    chk("wb_rf_we32", 64'(a_we), 64'(e_we));
    chk("wb_rf_we64", 64'(b_we), 64'(e_we));
    if (e_wbv) begin
      chk("wb_rf_wdata32", 64'(a_wdata), e_w32);
      chk("wb_rf_wdata64", b_wdata, e_w64);
      chk("wb_pc64", 64'(b_pc), 64'(m_pc));
      chk("wb_rf_waddr32", 64'(a_waddr), 64'(m_waddr));
    end
    l_stall = a_stallreq; l_wbv = a_wbv; l_we = a_we;
    l_a_wdata = a_wdata; l_b_wdata = b_wdata;
    @(posedge clk);
    od = m_discard;
    if (s.fl) begin
      if (od && s.rv) m_discard = 0;
      else if (m_waiting && !s.rv) m_discard = 1;
      // request issued but neither answered nor yet waited on: memory drops it
      if (is_ld && !m_have && !m_waiting && !(s.rv && !od) && rand_mode && q.size() > 0)
        void'(q.pop_back());
      m_have = 0; m_waiting = 0;
      m_valid = 0; m_op = 0; m_off = 0; m_we = 0; m_waddr = 0; m_pc = 0; m_res = 0;
    end else begin
      if (s.rv && od) m_discard = 0;
      else if (is_ld && !m_have && !od) begin
        if (s.rv) begin
          m_waiting = 0;
          if (s3e) begin m_have = 1; m_data = s.rd; end
        end else m_waiting = 1;
      end
      if (!s3e) begin m_have = 0; m_waiting = 0; end
      if (s3e && !s4e) begin
        m_valid = 0; m_op = 0; m_off = 0; m_we = 0; m_waddr = 0; m_pc = 0; m_res = 0;
      end else if (!s3e) begin
        m_valid = s.v; m_op = s.op; m_off = s.off; m_we = s.we;
        m_waddr = s.wa; m_pc = s.pc; m_res = s.res;
        if (rand_mode && s.v && s.op != 3'd0) q.push_back(int'($urandom_range(0, 3)));
      end
    end
  endtask

  task automatic load(input logic [2:0] op, input logic [2:0] off, input logic [4:0] wa);
    stim_t s;
    s = idle(); s.v = 1; s.op = op; s.off = off; s.we = 1; s.wa = wa; s.pc = 32'h400;
    step(s);
  endtask

  initial begin
    stim_t s;
    int sr_cnt;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_wb_valid", 64'(a_wbv | b_wbv), 64'h0);
    chk("reset_wdata", b_wdata | 64'(a_wdata), 64'h0);
    chk("reset_stallreq", 64'(a_stallreq | b_stallreq), 64'h0);
    rst = 1'b1;

    // ALU pass-through
    s = idle(); s.v = 1; s.we = 1; s.wa = 7; s.res = 64'h1234_5678; s.pc = 32'h100;
    step(s);
    step(idle());
    chk("alu_wdata", 64'(l_a_wdata), 64'h1234_5678);
    chk("alu_we", 64'(l_we), 64'h1);
    chk("alu_stallreq", 64'(l_stall), 64'h0);

    // LB / LBU zero-wait
    load(3'd1, 3'd1, 5'd3);
    s = idle(); s.rv = 1; s.rd = 64'h80FF_7F01; step(s);
    chk("lb_off1", 64'(l_a_wdata), 64'h0000_007F);
    load(3'd1, 3'd3, 5'd3);
    step(s);
    chk("lb_off3", 64'(l_a_wdata), 64'hFFFF_FF80);
    load(3'd2, 3'd3, 5'd3);
    step(s);
    chk("lbu_off3", 64'(l_a_wdata), 64'h0000_0080);

    // LH with three-cycle response latency
    load(3'd3, 3'd2, 5'd4);
    sr_cnt = 0;
    repeat (3) begin step(idle()); sr_cnt += int'(l_stall); end
    s = idle(); s.rv = 1; s.rd = 64'h8001_0000; step(s);
    sr_cnt += int'(l_stall);
    chk("lh_stall_cycles", 64'(sr_cnt), 64'd3);
    chk("lh_wdata", 64'(l_a_wdata), 64'hFFFF_8001);

    // response buffered across an external stall
    load(3'd5, 3'd0, 5'd9);
    s = idle(); s.rv = 1; s.rd = 64'h1122_3344; s.s3 = 1; s.s4 = 1; step(s);
    s = idle(); s.rd = 64'hBAD0_BAD0_BAD0_BAD0; s.s3 = 1; s.s4 = 1; step(s);
    chk("buf_hold_wdata", 64'(l_a_wdata), 64'h1122_3344);
    s = idle(); s.rd = 64'h5A5A_5A5A_5A5A_5A5A; step(s);
    chk("buf_release_wdata", 64'(l_a_wdata), 64'h1122_3344);
    chk("buf_release_valid", 64'(l_wbv), 64'h1);

    // flush while waiting: the stale response is discarded
    load(3'd5, 3'd0, 5'd10);
    step(idle());
    s = idle(); s.fl = 1; step(s);
    load(3'd5, 3'd0, 5'd11);
    s = idle(); s.rv = 1; s.rd = 64'hDEAD_BEEF; step(s);
    chk("drain_stallreq", 64'(l_stall), 64'h1);
    chk("drain_valid", 64'(l_wbv), 64'h0);
    step(idle());
    s = idle(); s.rv = 1; s.rd = 64'h42; step(s);
    chk("after_drain_wdata", 64'(l_a_wdata), 64'h42);
    chk("after_drain_valid", 64'(l_wbv), 64'h1);

    // 64-bit LWU
    load(3'd6, 3'd4, 5'd12);
    s = idle(); s.rv = 1; s.rd = 64'hF000_0001_0000_0000; step(s);
    chk("lwu64_wdata", l_b_wdata, 64'h0000_0000_F000_0001);

    // asynchronous reset in the middle of WAIT
    load(3'd5, 3'd0, 5'd13);
    step(idle());
    #2 rst = 1'b0;
    #1;
    chk("midreset_stallreq", 64'(a_stallreq | b_stallreq), 64'h0);
    chk("midreset_valid", 64'(a_wbv | b_wbv | a_we | b_we), 64'h0);
    chk("midreset_wdata", b_wdata | 64'(a_wdata) | 64'(b_pc) | 64'(a_waddr), 64'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    load(3'd5, 3'd0, 5'd14);
    s = idle(); s.rv = 1; s.rd = 64'h55; step(s);
    chk("post_reset_load", 64'(l_a_wdata), 64'h55);

    // randomized traffic
    rand_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      logic is_ld;
      int r;
      is_ld = m_valid && (m_op != 3'd0);
      s = idle();
      s.v  = ($urandom_range(0, 3) != 0);
      s.op = 3'($urandom_range(0, 7));
      s.off = 3'($urandom_range(0, 7));
      s.we = 1'($urandom_range(0, 1));
      s.wa = 5'($urandom_range(0, 31));
      s.res = {$urandom, $urandom};
      s.pc = $urandom;
      s.rd = {$urandom, $urandom};
      if (q.size() > 0) begin
        if (q[0] == 0) begin s.rv = 1; void'(q.pop_front()); end
        else q[0] = q[0] - 1;
      end else begin
        s.rv = !is_ld && ($urandom_range(0, 9) == 0);
      end
      r = int'($urandom_range(0, 7));
      if (r < 2) begin s.s3 = 1; s.s4 = 1; end
      else if (r == 2 && !is_ld) begin s.s3 = 1; s.s4 = 0; end
      s.fl = ($urandom_range(0, 11) == 0);
      step(s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Parametrised memory-access pipeline stage sitting between EX and WB. It generalises the word-only MEM stage:
- configurable data width (32/64);
- byte/half/word/double loads, zero- or sign-extended;
- a variable-latency data-memory response with a stall request;
- a one-entry response buffer;
- correct discard of responses belonging to flushed loads.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64.
- PC_W, 32, PC width.
- REG_AW, 5, register-file address width.
- STALL_W, 6, stall bus width; bit 3 holds this stage, bit 4 holds WB.
- OFF_W, $clog2(XLEN/8), byte-offset width (derived; do not override).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  kills the stage entry.
- stall  in  STALL_W  pipeline stall vector.
- ex_valid  in  1  EX entry valid.
- ex_pc  in  PC_W  PC of the EX entry.
- ex_load_op  in  3  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 LWU, 7 LD.
- ex_addr_lo  in  OFF_W  low bits of the effective address.
- ex_rf_we  in  1  register write enable.
- ex_rf_waddr  in  REG_AW  destination register.
- ex_result  in  XLEN  ALU result.
- mem_rvalid  in  1  data-memory read response valid.
- mem_rdata  in  XLEN  read data, naturally aligned lane.
- stallreq  out  1  request to hold the pipeline; set while a load lacks data.
- wb_valid, wb_pc, wb_rf_we, wb_rf_waddr, wb_rf_wdata  out  1/PC_W/1/REG_AW/XLEN  to WB and to the ID forwarding path.

## Operation
- Stage register update, in priority order:
  1. rst low: cleared.
  2. flush: cleared.
  3. stall[3] & !stall[4]: a bubble is loaded (valid=0).
  4. !stall[3]: captures the ex_* inputs.
  5. Otherwise: holds.
- A load entry is valid & load_op != NONE.
- When XLEN=32, LWU and LD behave as LW.
- data_ok = buf_full | mem_rvalid.
- stallreq = load entry & !data_ok, or load entry & state DRAIN.
- FSM states: EMPTY, WAIT, FULL, DRAIN.
  - EMPTY → WAIT: a load entry is present and mem_rvalid=0.
  - EMPTY → FULL: a load entry is present, mem_rvalid=1, and the entry is not leaving this cycle (stall[3]=1). Buffer captures mem_rdata.
  - EMPTY → EMPTY: a load entry is present, mem_rvalid=1, and the entry leaves.
  - WAIT → FULL or EMPTY on mem_rvalid, using the same leaving rule.
  - FULL → EMPTY when the entry leaves.
  - Flush in WAIT → DRAIN. The next mem_rvalid is discarded; then DRAIN → EMPTY. A new load entering during DRAIN is not served until after the discard.
  - Flush in FULL or EMPTY → EMPTY. The buffer is cleared.
- mem_rvalid in EMPTY with no load entry is ignored.
- Only one outstanding load is supported.
- Load alignment:
  - lane = (buf_full ? buf : mem_rdata) >> (addr_lo*8).
  - LB/LH/LW: sign-extend bit 7/15/31 to XLEN.
  - LBU/LHU/LWU: zero-extend.
  - LD: full lane.
- Misaligned offsets are not checked; the shifted lane is used as-is.
- wb_rf_wdata = load entry ? aligned data : ex_result.
- wb_rf_we = valid & rf_we.
- A load entry waiting for data drives wb_valid=0 and wb_rf_we=0.

## Timing
- Reset values: all wb_* = 0, stallreq = 0, state EMPTY, buffer 0.
- Non-load entry: wb_* are valid in the cycle after capture. Latency is one register from EX.
- Load:
  - wb_* are valid in the first cycle in which data_ok=1 and the state is not DRAIN.
  - Zero-wait memory (mem_rvalid in the capture cycle) adds no latency.
- wb_* are combinational from the stage register, the buffer and mem_rdata.
- stallreq is combinational and drops in the cycle mem_rvalid arrives.
- Simultaneous flush and mem_rvalid in WAIT: the response is consumed. The state goes to EMPTY, not DRAIN.
- Simultaneous flush and stall: flush wins.

## Structure
- Package mem_pkg holds:
  - load_op encodings;
  - FSM state encoding;
  - stall bit indices (STALL_MEM=3, STALL_WB=4).
- Sub-module load_align: combinational.
  - Parameter XLEN.
  - Inputs: raw data, offset, load_op.
  - Output: extended result.

## Test plan
- ALU pass-through: ex_result=0x1234_5678, rf_we=1, waddr=7, load_op=0 → next cycle wb_rf_wdata=0x1234_5678, wb_rf_we=1, stallreq=0.
- LB zero-wait: mem_rdata=0x80FF_7F01, addr_lo=1 → wb_rf_wdata=0x0000_007F. Same data, addr_lo=3 → 0xFFFF_FF80. LBU, addr_lo=3 → 0x0000_0080.
- LH 3-cycle latency: mem_rvalid arrives 3 cycles after capture → stallreq high exactly 3 cycles. With rdata=0x8001_0000, addr_lo=2 → wb_rf_wdata=0xFFFF_8001.
- Buffered response: mem_rvalid while stall[3]=stall[4]=1 for 2 cycles, after which mem_rdata changes to garbage → on release, wb_rf_wdata reflects the captured word.
- Flush in flight: load waiting → flush; a new LW enters; first mem_rvalid (0xDEAD_BEEF) is discarded; second (0x0000_0042) → wb_rf_wdata=0x42.
- XLEN=64, LWU, addr_lo=4, rdata=0xF000_0001_0000_0000 → wb_rf_wdata=0x0000_0000_F000_0001. Reset asserted mid-WAIT → all outputs 0 and state EMPTY immediately.
